parity_stream_scheduler: RTL and testbench

PARITY_STREAM_SCHEDULER -- requirements
Module: parity_stream_scheduler

---
 rtl/parity_sched_pkg.sv | 41 ++++
 rtl/parity_stream_scheduler_tracker.sv | 72 +++++++
 rtl/parity_stream_scheduler.sv | 178 +++++++++++++++++
 tb/tb_parity_stream_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : parity_sched_pkg
// Purpose  : Shared types for the parity stream scheduler: the scheduler
//            state encoding, the serial parity tracker state encoding and
//            the tracker next-state helper.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package parity_sched_pkg;

  // Scheduler control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Parity tracker states, named <ones parity>_<zeros parity>.
  typedef enum logic [1:0] {
    EVEN_EVEN = 2'd0,
    ODD_EVEN  = 2'd1,
    ODD_ODD   = 2'd2,
    EVEN_ODD  = 2'd3
  } par_state_t;

  // A one toggles the ones parity, a zero toggles the zeros parity.
  function automatic par_state_t par_next(input par_state_t cur, input logic bit_in);
    par_state_t nxt;
    nxt = EVEN_EVEN;
    case (cur)
      EVEN_EVEN: nxt = bit_in ? ODD_EVEN  : EVEN_ODD;
      ODD_EVEN:  nxt = bit_in ? EVEN_EVEN : ODD_ODD;
      ODD_ODD:   nxt = bit_in ? EVEN_ODD  : ODD_EVEN;
      EVEN_ODD:  nxt = bit_in ? ODD_ODD   : EVEN_EVEN;
      default:   nxt = EVEN_EVEN;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_stream_scheduler_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : parity_tracker
// Purpose  : Four-state serial parity FSM. Tracks whether the number of ones
//            and the number of zeros seen since the last clear are even.
//            Clear has priority over enable.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module parity_tracker
  import parity_sched_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic in_bit,
  output logic even_ones,
  output logic even_zeros
);

  par_state_t state;
  par_state_t state_next;

  // State register; reset lands in the empty-frame state (both counts even).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EVEN_EVEN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: clear restarts the count, enable folds in one serial bit.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = EVEN_EVEN;
    end else if (enable) begin
      state_next = par_next(state, in_bit);
    end
  end

  // Outputs decoded purely from the current state.
  always_comb begin
    even_ones  = 1'b0;
    even_zeros = 1'b0;
    case (state)
      EVEN_EVEN: begin
        even_ones  = 1'b1;
        even_zeros = 1'b1;
      end
      ODD_EVEN: begin
        even_ones  = 1'b0;
        even_zeros = 1'b1;
      end
      ODD_ODD: begin
        even_ones  = 1'b0;
        even_zeros = 1'b0;
      end
      EVEN_ODD: begin
        even_ones  = 1'b1;
        even_zeros = 1'b0;
      end
      default: begin
        even_ones  = 1'b1;
        even_zeros = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/parity_stream_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : parity_stream_scheduler
// Purpose  : Round-robin arbiter for two frame requesters. The granted frame
//            is serialised LSB first through a parity tracker and the result
//            (requester id, ones-even, zeros-even) is held until consumed.
//            Optional macro PARITY_SCHED_FLUSH_EN adds a flush input that
//            abandons the in-flight frame without touching priority.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module parity_stream_scheduler
  import parity_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef PARITY_SCHED_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             res_even_ones,
  output logic             res_even_zeros,
  output logic             busy
);

  // The counter must be able to hold WIDTH itself: the SHIFT state spends
  // WIDTH cycles feeding bits and one more cycle recognising completion,
  // which places res_valid WIDTH+1 edges after the accept edge.
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             prio;       // 0: req0 wins a tie, 1: req1 wins a tie
  logic             grant;      // requester selected in IDLE
  logic             any_valid;
  logic             accept;
  logic             res_hs;
  logic             flush_hit;
  logic             shift_en;
  logic             cnt_full;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             id_q;

`ifdef PARITY_SCHED_FLUSH_EN
  assign flush_hit = flush && (state != IDLE);
`else
  assign flush_hit = 1'b0;
`endif

  assign any_valid = req0_valid | req1_valid;
  assign accept    = (state == IDLE) && any_valid;
  assign cnt_full  = (cnt == CNT_DONE);
  assign shift_en  = (state == SHIFT) && !cnt_full && !flush_hit;
  assign res_hs    = (state == DONE) && res_ready && !flush_hit;

  // Arbitration: a lone requester wins, a tie goes to the priority holder.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides normal progress outside IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (flush_hit) begin
          state_next = IDLE;
        end else if (cnt_full) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (flush_hit || res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; ready is gated by reset so it drops immediately.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = reset_n && req0_valid && !grant;
        req1_ready = reset_n && req1_valid && grant;
      end
      SHIFT: begin
        busy = 1'b1;
      end
      DONE: begin
        res_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Frame shift register and bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= grant ? req1_data : req0_data;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  // Served-requester id and round-robin priority; priority only moves on a
  // completed result handshake, never on flush or reset discard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_q <= 1'b0;
      prio <= 1'b0;
    end else begin
      if (accept) begin
        id_q <= grant;
      end
      if (res_hs) begin
        prio <= ~id_q;
      end
    end
  end

  assign res_id = id_q;

  parity_tracker u_tracker (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (accept),
    .enable     (shift_en),
    .in_bit     (shreg[0]),
    .even_ones  (res_even_ones),
    .even_zeros (res_even_zeros)
  );

endmodule
`default_nettype wire

// File: tb/tb_parity_stream_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_parity_stream_scheduler
// Purpose  : Directed self-checking bench for parity_stream_scheduler with an
//            expected-result queue (WIDTH=8 instance plus a WIDTH=5 instance).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_parity_stream_scheduler;

  localparam int W  = 8;
  localparam int W5 = 5;

  typedef struct packed {
    logic id;
    logic eo;
    logic ez;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req1_valid, res_ready;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready, res_valid, res_id;
  logic         res_even_ones, res_even_zeros, busy;
`ifdef PARITY_SCHED_FLUSH_EN
  logic         flush;
`endif

  logic          a_valid, a_res_ready;
  logic [W5-1:0] a_data;
  logic          a_ready, a_res_valid, a_res_id, a_eo, a_ez, a_busy;
  logic          a_req1_ready;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t sb5[$];

  always #5 clk = ~clk;

  parity_stream_scheduler #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
`ifdef PARITY_SCHED_FLUSH_EN
    .flush          (flush),
`endif
    .req0_valid     (req0_valid),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_id         (res_id),
    .res_even_ones  (res_even_ones),
    .res_even_zeros (res_even_zeros),
    .busy           (busy)
  );

  parity_stream_scheduler #(.WIDTH(W5)) dut5 (
    .clk            (clk),
    .reset_n        (reset_n),
`ifdef PARITY_SCHED_FLUSH_EN
    .flush          (1'b0),
`endif
    .req0_valid     (a_valid),
    .req0_data      (a_data),
    .req0_ready     (a_ready),
    .req1_valid     (1'b0),
    .req1_data      ('0),
    .req1_ready     (a_req1_ready),
    .res_valid      (a_res_valid),
    .res_ready      (a_res_ready),
    .res_id         (a_res_id),
    .res_even_ones  (a_eo),
    .res_even_zeros (a_ez),
    .busy           (a_busy)
  );

  // Reference: count ones over the frame width, zeros are the remainder.
  function automatic exp_t model(input logic id, input logic [31:0] d, input int w);
    exp_t e;
    int   ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    e.id = id;
    e.eo = ((ones % 2) == 0);
    e.ez = (((w - ones) % 2) == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic id, input logic [W-1:0] d);
    if (id) begin
      req1_valid = 1'b1;
      req1_data  = d;
    end else begin
      req0_valid = 1'b1;
      req0_data  = d;
    end
  endtask

  // Called one time unit after a rising edge with the DUT in IDLE.
  task automatic take(input logic id);
    #1;
    chk("ready_granted", id ? req1_ready : req0_ready, 1);
    chk("ready_other", id ? req0_ready : req1_ready, 0);
    @(posedge clk);
    #1;
    sb.push_back(model(id, id ? req1_data : req0_data, W));
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("ready_low_in_shift", {req0_ready, req1_ready}, 0);
  endtask

  task automatic wait_result();
    int lat;
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, W + 1);
    if (res_valid && sb.size() > 0) begin
      chk("res_id", res_id, sb[0].id);
      chk("even_ones", res_even_ones, sb[0].eo);
      chk("even_zeros", res_even_zeros, sb[0].ez);
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    chk("res_valid_after_hs", res_valid, 0);
    chk("busy_after_hs", busy, 0);
  endtask

  initial begin
    int lat5;
    reset_n     = 1'b0;
    req0_valid  = 1'b1;
    req1_valid  = 1'b0;
    req0_data   = '0;
    req1_data   = '0;
    res_ready   = 1'b0;
    a_valid     = 1'b0;
    a_data      = '0;
    a_res_ready = 1'b0;
`ifdef PARITY_SCHED_FLUSH_EN
    flush       = 1'b0;
`endif
    #12;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_even_ones", res_even_ones, 1);
    chk("rst_even_zeros", res_even_zeros, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Tie after reset: req0 first, then req1.
    offer(0, 8'h01);
    offer(1, 8'h07);
    take(0);
    wait_result();
    consume();
    take(1);
    wait_result();
    consume();

    // Single requester, balanced frame.
    offer(0, 8'hA5);
    take(0);
    wait_result();
    consume();

    // Valid withdrawn before any edge: nothing accepted.
    offer(1, 8'h33);
    #2;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("no_accept_on_drop", busy, 0);

    // Consumer stalls for 5 cycles in DONE.
    offer(0, 8'h3C);
    take(0);
    wait_result();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_res_valid", res_valid, 1);
      chk("stall_res_id", res_id, sb[0].id);
      chk("stall_even_ones", res_even_ones, sb[0].eo);
      chk("stall_even_zeros", res_even_zeros, sb[0].ez);
      chk("stall_ready", {req0_ready, req1_ready}, 0);
      chk("stall_busy", busy, 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    consume();

    // Reset three cycles into SHIFT; priority currently with req1.
    offer(1, 8'h5A);
    take(1);
    repeat (3) @(posedge clk);
    #1;
    offer(0, 8'hFF);
    reset_n = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_res_id", res_id, 0);
    chk("midrst_even_ones", res_even_ones, 1);
    chk("midrst_even_zeros", res_even_zeros, 1);
    chk("midrst_ready", {req0_ready, req1_ready}, 0);
    sb.delete();
    #1;
    reset_n = 1'b1;
    take(0);
    offer(1, 8'h81);
    wait_result();
    consume();
    take(1);
    wait_result();
    consume();

`ifdef PARITY_SCHED_FLUSH_EN
    // Flush on SHIFT cycle 4; priority (req0) must be unchanged.
    offer(0, 8'h0F);
    take(0);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    chk("flush_busy", busy, 0);
    chk("flush_res_valid", res_valid, 0);
    offer(0, 8'h11);
    offer(1, 8'h22);
    #1;
    chk("flush_prio_req0", req0_ready, 1);
    chk("flush_prio_req1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
`endif

    // Odd width instance.
    a_valid = 1'b1;
    a_data  = 5'b00011;
    #1;
    chk("w5_ready", a_ready, 1);
    @(posedge clk);
    #1;
    sb5.push_back(model(1'b0, 32'(a_data), W5));
    a_valid = 1'b0;
    lat5 = 0;
    while (!a_res_valid && lat5 < 40) begin
      @(posedge clk);
      #1;
      lat5++;
    end
    chk("w5_latency", lat5, W5 + 1);
    if (a_res_valid && sb5.size() > 0) begin
      chk("w5_res_id", a_res_id, sb5[0].id);
      chk("w5_even_ones", a_eo, sb5[0].eo);
      chk("w5_even_zeros", a_ez, sb5[0].ez);
    end
    a_res_ready = 1'b1;
    @(posedge clk);
    #1;
    a_res_ready = 1'b0;
    if (sb5.size() > 0) void'(sb5.pop_front());
    chk("w5_res_valid_after_hs", a_res_valid, 0);
    chk("w5_busy_after_hs", a_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
